// File: rtl/ddr_traffic_pkg.sv
// Shared types and constants for the DDR user-side traffic generator/checker.
package ddr_traffic_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_SETTLE,
      ST_READ,
      ST_DONE
   } state_t;

   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] ERR_SAT   = 16'hFFFF;
endpackage

// File: rtl/ddr_user_traffic_gen_if.sv
// FIFO-side bundle between the traffic generator (master) and the DDR AXI controller (slave).
interface ddr_user_traffic_gen_if #(
   parameter int DATA_W = 16
);
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_mem_enable;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;

   modport master (
      output wr_en, wr_data, rd_mem_enable, rd_en,
      input  rd_data, rd_valid
   );

   modport slave (
      input  wr_en, wr_data, rd_mem_enable, rd_en,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/traffic_pattern_gen.sv
// Pattern source: incrementing counter, or a 16-bit Galois LFSR when TRAFFIC_LFSR_EN is defined.
module traffic_pattern_gen
   import ddr_traffic_pkg::*;
#(
   parameter int           W    = 16,
   parameter logic [W-1:0] SEED = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         advance,
   output logic [W-1:0] value
);
`ifdef TRAFFIC_LFSR_EN
   // An all-zero LFSR state would lock up, so a zero seed starts at 1.
   localparam logic [W-1:0] INIT = (SEED == '0) ? W'(1) : SEED;
   logic [W-1:0] value_nxt;
   assign value_nxt = value[0] ? ((value >> 1) ^ W'(LFSR_MASK)) : (value >> 1);
`else
   localparam logic [W-1:0] INIT = SEED;
   logic [W-1:0] value_nxt;
   assign value_nxt = value + W'(1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       value <= INIT;
      else if (clear)   value <= INIT;
      else if (advance) value <= value_nxt;
   end
endmodule

// File: rtl/ddr_user_traffic_gen.sv
// DDR user traffic generator/checker: writes a pattern to the write FIFO, settles, reads back and
// compares. Define TRAFFIC_LFSR_EN to use an LFSR pattern instead of an incrementing one.
module ddr_user_traffic_gen
   import ddr_traffic_pkg::*;
#(
   parameter int                DATA_W      = 16,
   parameter int                NUM_WORDS   = 4096,
   parameter logic [DATA_W-1:0] SEED        = '0,
   parameter int                SETTLE_CYC  = 32,
   parameter int                TIMEOUT_CYC = 4096
) (
   input  logic                   clk_fifo,
   input  logic                   locked_rst_n,
   input  logic                   start,
   ddr_user_traffic_gen_if.master bus,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   timeout,
   output logic [15:0]            err_cnt,
   output logic [15:0]            first_err_idx
);
   // state  | meaning
   // IDLE   | after reset, waiting for start
   // WRITE  | one pattern word per cycle into the write FIFO
   // SETTLE | idle gap before memory reads are enabled
   // READ   | draining the read FIFO and comparing
   // DONE   | results held until the next start

   state_t            state, state_nxt;
   logic [15:0]       wr_cnt, issued, checked, settle_tmr;
   logic [31:0]       wd_tmr;
   logic              cmp_pend, start_ok, rd_go, last_wr, mismatch, final_cmp, wd_expire;
   logic [DATA_W-1:0] wr_val, chk_val;

   assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign rd_go     = (state == ST_READ) && bus.rd_valid && (issued < 16'(NUM_WORDS));
   assign last_wr   = (wr_cnt == 16'(NUM_WORDS - 1));
   assign mismatch  = cmp_pend && (bus.rd_data != chk_val);
   assign final_cmp = cmp_pend && (checked == 16'(NUM_WORDS - 1));
   assign wd_expire = (state == ST_READ) && !rd_go && !final_cmp && (wd_tmr == '0);

   always_ff @(posedge clk_fifo or negedge locked_rst_n) begin
      if (!locked_rst_n) state <= ST_IDLE;
      else               state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (start) state_nxt = ST_WRITE;
         ST_WRITE:         if (last_wr) state_nxt = (SETTLE_CYC == 0) ? ST_READ : ST_SETTLE;
         ST_SETTLE:        if (settle_tmr == '0) state_nxt = ST_READ;
         ST_READ:          if (final_cmp || wd_expire) state_nxt = ST_DONE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.wr_en         = 1'b0;
      bus.wr_data       = SEED;
      bus.rd_en         = 1'b0;
      bus.rd_mem_enable = 1'b0;
      busy              = 1'b0;
      done              = 1'b0;
      case (state)
         ST_WRITE: begin
            bus.wr_en   = 1'b1;
            bus.wr_data = wr_val;
            busy        = 1'b1;
         end
         ST_SETTLE: busy = 1'b1;
         ST_READ: begin
            busy              = 1'b1;
            bus.rd_mem_enable = 1'b1;
            bus.rd_en         = rd_go;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign pass = done && !timeout && (err_cnt == '0);

   // Compare runs off cmp_pend regardless of state so an in-flight word still lands on timeout.
   always_ff @(posedge clk_fifo or negedge locked_rst_n) begin
      if (!locked_rst_n) begin
         wr_cnt        <= '0;
         issued        <= '0;
         checked       <= '0;
         settle_tmr    <= '0;
         wd_tmr        <= '0;
         cmp_pend      <= 1'b0;
         timeout       <= 1'b0;
         err_cnt       <= '0;
         first_err_idx <= '0;
      end else if (start_ok) begin
         wr_cnt        <= '0;
         issued        <= '0;
         checked       <= '0;
         settle_tmr    <= '0;
         wd_tmr        <= '0;
         cmp_pend      <= 1'b0;
         timeout       <= 1'b0;
         err_cnt       <= '0;
         first_err_idx <= '0;
      end else begin
         if (state == ST_WRITE) wr_cnt <= wr_cnt + 16'd1;

         if (state == ST_WRITE)       settle_tmr <= 16'(SETTLE_CYC - 1);
         else if (state == ST_SETTLE) settle_tmr <= settle_tmr - 16'd1;

         if ((state != ST_READ) || rd_go) wd_tmr <= 32'(TIMEOUT_CYC - 1);
         else if (wd_tmr != '0)           wd_tmr <= wd_tmr - 32'd1;

         cmp_pend <= rd_go;
         if (rd_go)    issued  <= issued + 16'd1;
         if (cmp_pend) checked <= checked + 16'd1;

         if (mismatch) begin
            if (err_cnt != ERR_SAT) err_cnt <= err_cnt + 16'd1;
            if (err_cnt == '0)      first_err_idx <= checked;
         end

         if (wd_expire) timeout <= 1'b1;
      end
   end

   traffic_pattern_gen #(.W(DATA_W), .SEED(SEED)) u_wr_pat (
      .clk     (clk_fifo),
      .rst_n   (locked_rst_n),
      .clear   (start_ok),
      .advance (state == ST_WRITE),
      .value   (wr_val)
   );

   traffic_pattern_gen #(.W(DATA_W), .SEED(SEED)) u_chk_pat (
      .clk     (clk_fifo),
      .rst_n   (locked_rst_n),
      .clear   (start_ok),
      .advance (cmp_pend),
      .value   (chk_val)
   );
endmodule

// File: tb/tb_ddr_user_traffic_gen.sv
// Bench for ddr_user_traffic_gen: a FIFO loopback with random read gaps and word corruption,
// checked against a pattern model computed from the pattern rules (honours TRAFFIC_LFSR_EN).
`timescale 1ns/1ps
module tb_ddr_user_traffic_gen;
   localparam int          N      = 16;
   localparam int          SETTLE = 3;
   localparam int          TMO    = 64;
   localparam logic [15:0] SEED0  = 16'h0000;
   localparam logic [15:0] SEED1  = 16'h1234;

   logic        clk_fifo     = 1'b0;
   logic        locked_rst_n = 1'b0;
   logic        start        = 1'b0;
   logic        start1       = 1'b0;
   logic        busy, done, pass, timeout;
   logic        busy1, done1, pass1, timeout1;
   logic [15:0] err_cnt, first_err_idx, err_cnt1, first_err_idx1;

   ddr_user_traffic_gen_if #(.DATA_W(16)) bus0 ();
   ddr_user_traffic_gen_if #(.DATA_W(16)) bus1 ();

   ddr_user_traffic_gen #(
      .DATA_W(16), .NUM_WORDS(N), .SEED(SEED0), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk_fifo(clk_fifo), .locked_rst_n(locked_rst_n), .start(start), .bus(bus0.master),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .err_cnt(err_cnt), .first_err_idx(first_err_idx)
   );

   ddr_user_traffic_gen #(
      .DATA_W(16), .NUM_WORDS(1), .SEED(SEED1), .SETTLE_CYC(0), .TIMEOUT_CYC(TMO)
   ) dut1 (
      .clk_fifo(clk_fifo), .locked_rst_n(locked_rst_n), .start(start1), .bus(bus1.master),
      .busy(busy1), .done(done1), .pass(pass1), .timeout(timeout1),
      .err_cnt(err_cnt1), .first_err_idx(first_err_idx1)
   );

   always #5 clk_fifo = ~clk_fifo;

   int          n_cmp = 0, n_bad = 0, cyc = 0;
   logic [15:0] fifo_q[$];
   logic [15:0] wlog[$];
   logic [15:0] cx [N];
   int          wr_first, wr_last, rme_rise, to_rise, done_rise, err_rise, corrupt_acc, last_acc, pop_cnt;
   bit          resp_en = 1'b1, s_rd_en = 1'b0, both_hi = 1'b0, busy_at_done = 1'b0;

   function automatic logic [15:0] pattern(input logic [15:0] seed, input int k);
      logic [15:0] v;
`ifdef TRAFFIC_LFSR_EN
      v = (seed == 16'h0) ? 16'h0001 : seed;
      for (int i = 0; i < k; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
`else
      v = seed + 16'(k);
`endif
      return v;
   endfunction

   task automatic clear_trk();
      fifo_q.delete();
      wlog.delete();
      wr_first = -1; wr_last = -1; rme_rise = -1; to_rise = -1; done_rise = -1;
      err_rise = -1; corrupt_acc = -1; last_acc = -1; pop_cnt = 0;
      both_hi = 1'b0; busy_at_done = 1'b0;
   endtask

   // One clock of the controller-side FIFO model for dut; returns at the falling edge.
   task automatic cycle();
      logic [15:0] w;
      w = 16'h0;
      @(posedge clk_fifo);
      cyc++;
      if (s_rd_en) begin
         last_acc = cyc - 1;
         w = (fifo_q.size() > 0) ? fifo_q.pop_front() : 16'hDEAD;
         if (pop_cnt < N && cx[pop_cnt] != 16'h0) begin
            w = w ^ cx[pop_cnt];
            if (corrupt_acc < 0) corrupt_acc = cyc - 1;
         end
         pop_cnt++;
      end
      #1;
      if (s_rd_en) bus0.rd_data = w;
      bus0.rd_valid = resp_en && bus0.rd_mem_enable && (fifo_q.size() > 0) && ($urandom_range(0, 3) != 0);
      @(negedge clk_fifo);
      s_rd_en = bus0.rd_en;
      if (bus0.wr_en) begin
         fifo_q.push_back(bus0.wr_data);
         wlog.push_back(bus0.wr_data);
         if (wr_first < 0) wr_first = cyc;
         wr_last = cyc;
      end
      if (bus0.wr_en && bus0.rd_en) both_hi = 1'b1;
      if (bus0.rd_mem_enable && rme_rise < 0) rme_rise = cyc;
      if (timeout && to_rise < 0) to_rise = cyc;
      if (done && done_rise < 0) begin done_rise = cyc; busy_at_done = busy; end
      if (err_cnt != 16'h0 && err_rise < 0) err_rise = cyc;
   endtask

   task automatic test_reset();
      bus0.rd_valid = 1'b0; bus0.rd_data = 16'h0;
      bus1.rd_valid = 1'b0; bus1.rd_data = 16'h0;
      repeat (2) @(negedge clk_fifo);
      n_cmp++;
      if ({busy, done, pass, timeout, bus0.wr_en, bus0.rd_en, bus0.rd_mem_enable, err_cnt, first_err_idx} !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got b%0b d%0b p%0b t%0b err=%0d idx=%0d, required all 0",
                           busy, done, pass, timeout, err_cnt, first_err_idx);
      end
      n_cmp++;
      if (bus0.wr_data !== SEED0) begin
         n_bad++; $display("FAIL reset_wr_data: got %h required %h", bus0.wr_data, SEED0);
      end
      locked_rst_n = 1'b1;
      repeat (2) cycle();
   endtask

   task automatic test_loopback(input string tag);
      int t;
      for (int i = 0; i < N; i++) cx[i] = 16'h0;
      clear_trk(); t = cyc; start = 1'b1; cycle(); start = 1'b0;
      for (int i = 0; i < 400 && done_rise < 0; i++) cycle();
      n_cmp++;
      if (done_rise < 0) begin n_bad++; $display("FAIL %s_done: done not seen in 400 cycles, required 1", tag); end
      n_cmp++;
      if (wlog.size() != N) begin n_bad++; $display("FAIL %s_wr_count: got %0d required %0d", tag, wlog.size(), N); end
      for (int k = 0; k < N && k < wlog.size(); k++) begin
         n_cmp++;
         if (wlog[k] !== pattern(SEED0, k)) begin
            n_bad++; $display("FAIL %s_wr_data[%0d]: got %h required %h", tag, k, wlog[k], pattern(SEED0, k));
         end
      end
`ifdef TRAFFIC_LFSR_EN
      n_cmp++;
      if (wlog.size() < 4 || {wlog[0], wlog[1], wlog[2], wlog[3]} !== {16'h0001, 16'hB400, 16'h5A00, 16'h2D00}) begin
         n_bad++; $display("FAIL %s_lfsr_head: got %0d words, required 0001 B400 5A00 2D00", tag, wlog.size());
      end
`endif
      n_cmp++;
      if (wr_first != t + 1 || wr_last != t + N) begin
         n_bad++; $display("FAIL %s_wr_window: got %0d..%0d required %0d..%0d", tag, wr_first, wr_last, t + 1, t + N);
      end
      n_cmp++;
      if (rme_rise != t + N + SETTLE + 1) begin
         n_bad++; $display("FAIL %s_rme_rise: got %0d required %0d", tag, rme_rise, t + N + SETTLE + 1);
      end
      n_cmp++;
      if (done_rise != last_acc + 2 || busy_at_done !== 1'b0) begin
         n_bad++; $display("FAIL %s_done_timing: done at %0d busy=%0b, required %0d busy=0", tag, done_rise, busy_at_done, last_acc + 2);
      end
      n_cmp++;
      if ({pass, timeout, err_cnt, first_err_idx} !== {1'b1, 1'b0, 16'h0, 16'h0}) begin
         n_bad++; $display("FAIL %s_result: got pass=%0b to=%0b err=%0d idx=%0d required 1 0 0 0", tag, pass, timeout, err_cnt, first_err_idx);
      end
      n_cmp++;
      if (both_hi) begin n_bad++; $display("FAIL %s_wr_rd_overlap: got 1 required 0", tag); end
      repeat (5) cycle();
      n_cmp++;
      if ({done, pass, busy} !== 3'b110) begin
         n_bad++; $display("FAIL %s_hold: got done=%0b pass=%0b busy=%0b required 1 1 0", tag, done, pass, busy);
      end
   endtask

   task automatic test_corrupt5();
      for (int i = 0; i < N; i++) cx[i] = 16'h0;
      cx[5] = 16'h0001;
      clear_trk(); start = 1'b1; cycle(); start = 1'b0;
      for (int i = 0; i < 400 && done_rise < 0; i++) cycle();
      n_cmp++;
      if (done_rise < 0) begin n_bad++; $display("FAIL corrupt_done: done not seen in 400 cycles, required 1"); end
      n_cmp++;
      if ({err_cnt, first_err_idx, pass, timeout} !== {16'd1, 16'd5, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL corrupt_result: got err=%0d idx=%0d pass=%0b to=%0b required 1 5 0 0", err_cnt, first_err_idx, pass, timeout);
      end
      n_cmp++;
      if (err_rise != corrupt_acc + 2) begin
         n_bad++; $display("FAIL corrupt_err_latency: got %0d required %0d", err_rise, corrupt_acc + 2);
      end
   endtask

   task automatic test_random_errors();
      int  exp_cnt, exp_first;
      bit  seen;
      for (int p = 0; p < 3; p++) begin
         exp_cnt = 0; exp_first = 0; seen = 1'b0;
         for (int i = 0; i < N; i++) begin
            cx[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 16'hFFFF)) : 16'h0;
            if (cx[i] != 16'h0) begin
               exp_cnt++;
               if (!seen) begin exp_first = i; seen = 1'b1; end
            end
         end
         clear_trk(); start = 1'b1; cycle(); start = 1'b0;
         for (int i = 0; i < 400 && done_rise < 0; i++) cycle();
         n_cmp++;
         if (done_rise < 0) begin n_bad++; $display("FAIL rand%0d_done: done not seen in 400 cycles, required 1", p); end
         n_cmp++;
         if ({err_cnt, first_err_idx, pass} !== {16'(exp_cnt), 16'(exp_first), (exp_cnt == 0)}) begin
            n_bad++; $display("FAIL rand%0d_result: got err=%0d idx=%0d pass=%0b required %0d %0d %0b",
                              p, err_cnt, first_err_idx, pass, exp_cnt, exp_first, exp_cnt == 0);
         end
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < N; i++) cx[i] = 16'h0;
      resp_en = 1'b0;
      clear_trk(); start = 1'b1; cycle(); start = 1'b0;
      for (int i = 0; i < N + SETTLE + TMO + 40 && done_rise < 0; i++) cycle();
      resp_en = 1'b1;
      n_cmp++;
      if (done_rise < 0) begin n_bad++; $display("FAIL timeout_done: done not seen, required 1"); end
      n_cmp++;
      if (to_rise != rme_rise + TMO || done_rise != to_rise) begin
         n_bad++; $display("FAIL timeout_timing: timeout at %0d done at %0d, required both %0d", to_rise, done_rise, rme_rise + TMO);
      end
      n_cmp++;
      if ({timeout, pass, bus0.rd_mem_enable} !== 3'b100) begin
         n_bad++; $display("FAIL timeout_result: got to=%0b pass=%0b rme=%0b required 1 0 0", timeout, pass, bus0.rd_mem_enable);
      end
   endtask

   task automatic test_busy_start_and_reset();
      for (int i = 0; i < N; i++) cx[i] = 16'h0;
      clear_trk(); start = 1'b1; cycle(); start = 1'b0;
      for (int i = 0; i < 50 && wlog.size() < 3; i++) cycle();
      start = 1'b1; cycle(); start = 1'b0;
      for (int i = 0; i < 50 && wlog.size() < 8; i++) cycle();
      locked_rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, pass, timeout, bus0.wr_en, bus0.rd_en, bus0.rd_mem_enable, err_cnt, first_err_idx} !== '0) begin
         n_bad++; $display("FAIL midreset_outputs: got b%0b d%0b p%0b t%0b wr=%0b required all 0", busy, done, pass, timeout, bus0.wr_en);
      end
      n_cmp++;
      if (bus0.wr_data !== SEED0 || bus1.wr_data !== SEED1) begin
         n_bad++; $display("FAIL midreset_wr_data: got %h/%h required %h/%h", bus0.wr_data, bus1.wr_data, SEED0, SEED1);
      end
      n_cmp++;
      if (wlog.size() != 8 || wr_last - wr_first != 7) begin
         n_bad++; $display("FAIL busy_start_words: got %0d words over %0d cycles, required 8 over 8", wlog.size(), wr_last - wr_first + 1);
      end
      for (int k = 0; k < wlog.size(); k++) begin
         n_cmp++;
         if (wlog[k] !== pattern(SEED0, k)) begin
            n_bad++; $display("FAIL busy_start_data[%0d]: got %h required %h", k, wlog[k], pattern(SEED0, k));
         end
      end
      @(negedge clk_fifo);
      locked_rst_n = 1'b1;
      s_rd_en = 1'b0;
      clear_trk();
      repeat (3) cycle();
      n_cmp++;
      if ({busy, done, bus0.wr_en} !== 3'b000) begin
         n_bad++; $display("FAIL postreset_idle: got busy=%0b done=%0b wr=%0b required 0 0 0", busy, done, bus0.wr_en);
      end
   endtask

   task automatic test_single();
      logic [15:0] q1[$];
      logic [15:0] w, w0;
      int          t, wf, wcnt, rme, dn;
      bit          acc;
      wf = -1; wcnt = 0; rme = -1; dn = -1; acc = 1'b0; w = 16'h0; w0 = 16'h0;
      t = cyc; start1 = 1'b1; cycle(); start1 = 1'b0;
      for (int i = 0; i < 30 && dn < 0; i++) begin
         if (acc) bus1.rd_data = w;
         if (bus1.wr_en) begin
            q1.push_back(bus1.wr_data);
            if (wf < 0) begin wf = cyc; w0 = bus1.wr_data; end
            wcnt++;
         end
         if (bus1.rd_mem_enable && rme < 0) rme = cyc;
         if (done1 && dn < 0) dn = cyc;
         bus1.rd_valid = bus1.rd_mem_enable && (q1.size() > 0);
         #1;
         acc = bus1.rd_en;
         if (acc) w = q1.pop_front();
         if (dn < 0) cycle();
      end
      n_cmp++;
      if (wf != t + 1 || wcnt != 1 || w0 !== pattern(SEED1, 0)) begin
         n_bad++; $display("FAIL single_write: got cyc %0d n=%0d data=%h required cyc %0d n=1 data=%h", wf, wcnt, w0, t + 1, pattern(SEED1, 0));
      end
      n_cmp++;
      if (rme != t + 2) begin n_bad++; $display("FAIL single_rme_rise: got %0d required %0d", rme, t + 2); end
      n_cmp++;
      if (dn != t + 4) begin n_bad++; $display("FAIL single_done: got %0d required %0d", dn, t + 4); end
      n_cmp++;
      if ({pass1, timeout1, err_cnt1} !== {1'b1, 1'b0, 16'h0}) begin
         n_bad++; $display("FAIL single_result: got pass=%0b to=%0b err=%0d required 1 0 0", pass1, timeout1, err_cnt1);
      end
   endtask

   initial begin
      clear_trk();
      test_reset();
      test_loopback("loopback");
      test_corrupt5();
      test_random_errors();
      test_timeout();
      test_busy_start_and_reset();
      test_loopback("loopback_after_reset");
      test_single();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation still running at 500us, required finish");
      $fatal(1);
   end
endmodule

// File: doc/ddr_user_traffic_gen.md
# ddr_user_traffic_gen

User-side traffic generator and checker for the DDR AXI controller's FIFO interface, clocked by `clk_fifo`. On `start` it writes a deterministic 16-bit pattern into the controller's write FIFO, waits a settle interval, and then enables memory reads. It drains the read FIFO, compares every returned word against the regenerated pattern, and reports pass/fail, an error count and the first failing index. It replaces hand-written stimulus in benches and serves as an on-board self-test master.

## Interface
- `DATA_W`, 16: FIFO data width.
- `NUM_WORDS`, 4096: words written and read per pass; range 1..65535.
- `SEED`, 16'h0000: first pattern word.
- `SETTLE_CYC`, 32: idle cycles between the last write and `rd_mem_enable` rising; range 0..65535.
- `TIMEOUT_CYC`, 4096: maximum cycles in READ without an accepted word before the pass is aborted.
- `clk_fifo`, in, 1: block clock; same clock as the controller's `wr_clk`/`rd_clk`.
- `locked_rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse that begins a pass.
- `wr_en`, out, 1: write FIFO write request.
- `wr_data`, out, DATA_W: write FIFO data.
- `rd_mem_enable`, out, 1: allows the controller to read memory.
- `rd_en`, out, 1: read FIFO read request.
- `rd_data`, in, DATA_W: read FIFO data, valid one cycle after an accepted `rd_en`.
- `rd_valid`, in, 1: read FIFO has data.
- `busy`, out, 1: a pass is in progress.
- `done`, out, 1: the pass has finished (level signal).
- `pass`, out, 1: `done` asserted, no mismatches, and no timeout.
- `timeout`, out, 1: the pass aborted in READ.
- `err_cnt`, out, 16: mismatch count; saturates at 16'hFFFF.
- `first_err_idx`, out, 16: index of the first mismatch; 0 if there was none.

## Operation
- States: IDLE, WRITE, SETTLE, READ, DONE.
- IDLE: `start` moves to WRITE and clears all counters, flags and pattern generators.
- WRITE:
  - `wr_en` is high for exactly NUM_WORDS consecutive cycles.
  - Word k is `pattern(k)`.
  - There is no backpressure; the controller's write FIFO absorbs NUM_WORDS.
  - After word NUM_WORDS-1, go to SETTLE.
- SETTLE:
  - Count SETTLE_CYC cycles; with 0, go straight to READ.
  - Then go to READ and set `rd_mem_enable`, held until DONE.
- READ:
  - `rd_en = (state==READ) && rd_valid && (issued < NUM_WORDS)` (combinational).
  - Each accepted `rd_en` increments `issued`.
  - One cycle later, `rd_data` is compared with `pattern(checked)`, then `checked` increments.
  - On mismatch: `err_cnt` increments (saturating); if this is the first mismatch, `first_err_idx` is set to `checked`.
  - When `checked == NUM_WORDS`, go to DONE.
  - Watchdog: reset on every accepted word. If it reaches TIMEOUT_CYC, set `timeout` and go to DONE; any in-flight compare still completes that cycle.
- DONE:
  - `done` = 1; `rd_mem_enable` = 0.
  - Results hold until `start`, which begins a new pass as from IDLE.
- `start` while busy (WRITE/SETTLE/READ) is ignored.
- Default pattern: `pattern(k) = SEED + k`, modulo 2^16.

## Timing
- Reset values:
  - All outputs are 0; `wr_data` = SEED.
  - The state machine returns to IDLE immediately on reset, including mid-pass.
- `start` is sampled at cycle t:
  - `busy` = 1 and first `wr_en` at t+1; last `wr_en` at t+NUM_WORDS.
  - `rd_mem_enable` rises at t+NUM_WORDS+SETTLE_CYC+1.
- The compare result (`err_cnt` update) is visible two cycles after the accepted `rd_en`.
- `done` rises the cycle after the final compare; `busy` falls in that same cycle.
- `wr_en` and `rd_en` are never both high.

## Configuration
- `TRAFFIC_LFSR_EN` defined:
  - `pattern(k)` is a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - It is seeded with SEED, or with 16'h0001 if SEED is 0.
  - It advances once per word; write and check sequences are identical.
- Not defined: incrementing pattern only, and no LFSR logic is synthesized.

## Structure
- Package `ddr_traffic_pkg`: state enum, LFSR mask constant, `ERR_SAT` = 16'hFFFF.
- Sub-module `traffic_pattern_gen` (ports: clk, rst_n, `clear`, `advance`, `value`) holds the counter or LFSR.
- It is instantiated twice: once for the writer, once for the checker.

## Test plan
- Loopback, NUM_WORDS=16, SEED=0, `start` -> `wr_data` 0..15, `done`=1, `pass`=1, `err_cnt`=0.
- Corrupt returned word 5 (XOR 16'h0001) -> `err_cnt`=1, `first_err_idx`=5, `pass`=0.
- Hold `rd_valid` low, TIMEOUT_CYC=64 -> `timeout`=1 exactly 64 cycles after entering READ, then `done`=1 and `pass`=0.
- Pulse `start` during WRITE, then reset at word 8 -> the extra `start` is ignored; on reset all outputs go to 0 and `wr_data` returns to SEED.
- SETTLE_CYC=0 and NUM_WORDS=1 -> `rd_mem_enable` rises the cycle after the single write; the pass completes with `pass`=1.
- With `TRAFFIC_LFSR_EN`, SEED=0 -> first words 16'h0001, 16'hB400, 16'h5A00, 16'h2D00; `pass`=1.
